// File: rtl/filter_pkg.sv
// Shared types and constants for the L=3 parallel FIR datapath.
//   L         : parallelism (samples per block)
//   sample_t  : saturated Q1.31 output sample
//   acc_t     : 64-bit scaled filter output before narrowing
//   block_t   : one block of L samples
//   SAT_MAX/SAT_MIN : Q1.31 saturation limits
//   sat_count : number of set saturation bits in a block
package filter_pkg;

  localparam int unsigned L = 3;

  typedef logic signed [31:0] sample_t;
  typedef logic signed [63:0] acc_t;
  typedef sample_t block_t [L];

  localparam sample_t SAT_MAX = 32'h7FFF_FFFF;
  localparam sample_t SAT_MIN = 32'h8000_0000;

  function automatic logic [1:0] sat_count(input logic [L-1:0] bits);
    logic [1:0] n;
    n = '0;
    for (int unsigned i = 0; i < L; i++) begin
      n = n + 2'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational saturating narrower: acc_t -> sample_t (Q1.31).
// Ports:
//   din  : 64-bit signed value, already scaled
//   dout : din clamped to [SAT_MIN, SAT_MAX]
//   sat  : 1 when clamping took place
module sat_narrow
  import filter_pkg::*;
(
  input  acc_t    din,
  output sample_t dout,
  output logic    sat
);

  // The value fits in 32 bits exactly when bits [63:31] are all copies of the sign.
  logic [32:0] hi;

  always_comb begin
    hi   = din[63:31];
    sat  = !((hi == '0) || (hi == '1));
    dout = sample_t'(din[31:0]);
    if (sat) begin
      dout = din[63] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/block_serializer.sv
// Downstream stage of the L=3 parallel FIR. Accepts one block of three
// scaled 64-bit outputs per handshake, saturates each to Q1.31, buffers
// whole blocks in a small FIFO and emits them as a serial stream in order
// y[3k], y[3k+1], y[3k+2].
// Parameters: IN_W (element width), OUT_W (sample width), FIFO_DEPTH (blocks,
//   power of two, >=2).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : block handshake, in_y0..in_y2 block elements
//   out_valid/out_ready   : serial sample handshake, out_data sample,
//                           out_last marks the third sample of a block
//   sat_flag/sat_clr      : sticky saturation indicator and its clear
//   sat_cnt               : saturated-element count (BLOCK_SER_SAT_CNT_EN only)
// Optional feature macro: BLOCK_SER_SAT_CNT_EN
module block_serializer
  import filter_pkg::*;
#(
  parameter int unsigned IN_W       = 64,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_y0,
  input  logic [IN_W-1:0]   in_y1,
  input  logic [IN_W-1:0]   in_y2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              sat_flag,
  input  logic              sat_clr
`ifdef BLOCK_SER_SAT_CNT_EN
  ,
  output logic [15:0]       sat_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  typedef logic [L-1:0][OUT_W-1:0] entry_t;

  // Saturation of the incoming block
  acc_t          in_blk  [L];
  sample_t       sat_val [L];
  logic [L-1:0]  sat_bit;
  entry_t        wr_entry;
  logic [1:0]    n_sat;

  always_comb begin
    in_blk[0] = acc_t'(in_y0);
    in_blk[1] = acc_t'(in_y1);
    in_blk[2] = acc_t'(in_y2);
  end

  for (genvar gi = 0; gi < L; gi++) begin : g_sat
    sat_narrow u_sat (
      .din  (in_blk[gi]),
      .dout (sat_val[gi]),
      .sat  (sat_bit[gi])
    );
  end

  always_comb begin
    wr_entry = '0;
    for (int unsigned i = 0; i < L; i++) begin
      wr_entry[i] = OUT_W'(sat_val[i]);
    end
    n_sat = sat_count(sat_bit);
  end

  // State
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         phase_q, phase_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               sat_flag_q, sat_flag_d;
  logic [15:0]        sat_cnt_q, sat_cnt_d;
  logic [16:0]        sat_sum;

  logic push, advance, pop;

  // in_ready/out_valid come from occupancy only, so no in_* -> out_* comb path.
  assign in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_flag_q;

  always_comb begin
    push    = in_valid && in_ready;
    advance = out_valid && out_ready;
    pop     = advance && (phase_q == P2);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    phase_d = phase_q;
    if (advance) begin
      case (phase_q)
        P0:      phase_d = P1;
        P1:      phase_d = P2;
        default: phase_d = P0;
      endcase
    end

    // Registered read of the next head sample; reading mem_d lets a block
    // written into an empty FIFO appear on out_data one cycle after the push.
    out_data_d = mem_d[rd_ptr_d][phase_d];
    out_last_d = (phase_d == P2) && (count_d != '0);

    // A saturating push wins over a same-cycle clear.
    sat_flag_d = sat_flag_q;
    if (push && (n_sat != '0)) begin
      sat_flag_d = 1'b1;
    end else if (sat_clr) begin
      sat_flag_d = 1'b0;
    end

    sat_sum   = {1'b0, sat_cnt_q} + 17'(n_sat);
    sat_cnt_d = sat_cnt_q;
    if (push && (n_sat != '0)) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end else if (sat_clr) begin
      sat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= P0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      sat_flag_q <= sat_flag_d;
    end
  end

`ifdef BLOCK_SER_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt_q = '0;
`endif

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer. The reference model treats the
// design as a queue of saturated samples: every accepted block appends three
// clamped values, every serial handshake must remove the oldest one.
module tb_block_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_y0, in_y1, in_y2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        sat_flag;
  logic        sat_clr;
`ifdef BLOCK_SER_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  block_serializer #(.IN_W(64), .OUT_W(32), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y0     (in_y0),
    .in_y1     (in_y1),
    .in_y2     (in_y2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
`ifdef BLOCK_SER_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic        flag_m = 1'b0;
  int          cnt_m = 0;

  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;

  function automatic logic [31:0] sat_model(input logic [63:0] v);
    longint s;
    logic [31:0] r;
    s = v;
    if (s > MAXV) r = 32'h7FFF_FFFF;
    else if (s < MINV) r = 32'h8000_0000;
    else r = v[31:0];
    return r;
  endfunction

  function automatic int is_sat(input logic [63:0] v);
    longint s;
    s = v;
    return ((s > MAXV) || (s < MINV)) ? 1 : 0;
  endfunction

  function automatic logic [63:0] gen_val();
    longint r;
    case ($urandom % 5)
      0: r = longint'($signed($urandom));
      1: r = MAXV + 1 + longint'($urandom % 1000);
      2: r = MINV - 1 - longint'($urandom % 1000);
      3: begin
        case ($urandom % 4)
          0: r = MAXV;
          1: r = MAXV + 1;
          2: r = MINV;
          default: r = MINV - 1;
        endcase
      end
      default: r = longint'($urandom % 100);
    endcase
    return r;
  endfunction

  // One clock: record the handshakes seen this cycle, update the model, then
  // advance to just after the rising edge.
  task automatic step(output bit pushed);
    int n;
    @(negedge clk);
    pushed = 1'b0;
    n = 0;
    if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    if (in_valid && in_ready) begin
      pushed = 1'b1;
      exp_q.push_back({1'b0, sat_model(in_y0)});
      exp_q.push_back({1'b0, sat_model(in_y1)});
      exp_q.push_back({1'b1, sat_model(in_y2)});
      n = is_sat(in_y0) + is_sat(in_y1) + is_sat(in_y2);
    end
    if (pushed && n != 0) begin
      flag_m = 1'b1;
      cnt_m  = (cnt_m + n > 65535) ? 65535 : cnt_m + n;
    end else if (sat_clr) begin
      flag_m = 1'b0;
      cnt_m  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    in_y0 = '0; in_y1 = '0; in_y2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    flag_m = 1'b0; cnt_m = 0;
    exp_q.delete(); got_q.delete();
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    vectors++;
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    vectors++;
    if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag got %b exp 0", sat_flag); end
`ifdef BLOCK_SER_SAT_CNT_EN
    vectors++;
    if (sat_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_sat_cnt got %h exp 0", sat_cnt); end
`endif
  endtask

  task automatic test_basic();
    bit p;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'd1; exp_d[1] = 32'd2; exp_d[2] = 32'd3;
    out_ready = 1'b1;
    in_valid = 1'b1; in_y0 = 64'd1; in_y1 = 64'd2; in_y2 = 64'd3;
    step(p);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 2)) begin
        miscompares++;
        $display("FAIL basic_sample%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, exp_d[i], (i == 2));
      end
      step(p);
    end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty got %b exp 0", out_valid); end
    vectors++;
    if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL basic_sat_flag got %b exp 0", sat_flag); end
  endtask

  task automatic test_saturation();
    bit p;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_y0 = 64'sh1_0000_0000; in_y1 = -64'sh1_0000_0000; in_y2 = 64'd5;
    step(p);
    in_valid = 1'b0;
    repeat (3) step(p);
    vectors++;
    if (got_q.size() !== 3) begin
      miscompares++; $display("FAIL sat_len got %0d exp 3", got_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== {1'b0, 32'h7FFF_FFFF} || got_q[1] !== {1'b0, 32'h8000_0000} ||
          got_q[2] !== {1'b1, 32'd5}) begin
        miscompares++;
        $display("FAIL sat_values got %h %h %h exp 07fffffff 080000000 100000005",
                 got_q[0], got_q[1], got_q[2]);
      end
    end
    vectors++;
    if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_flag_set got %b exp 1", sat_flag); end
`ifdef BLOCK_SER_SAT_CNT_EN
    vectors++;
    if (sat_cnt !== 16'd2) begin miscompares++; $display("FAIL sat_cnt got %0d exp 2", sat_cnt); end
`endif
    sat_clr = 1'b1;
    step(p);
    sat_clr = 1'b0;
    vectors++;
    if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL sat_flag_clr got %b exp 0", sat_flag); end
`ifdef BLOCK_SER_SAT_CNT_EN
    vectors++;
    if (sat_cnt !== 16'd0) begin miscompares++; $display("FAIL sat_cnt_clr got %0d exp 0", sat_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    bit p;
    logic [31:0] head;
    int waited;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_y0 = gen_val(); in_y1 = gen_val(); in_y2 = gen_val();
    head = sat_model(in_y0);
    step(p);
    in_y0 = gen_val(); in_y1 = gen_val(); in_y2 = gen_val();
    step(p);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full got in_ready=%b exp 0", in_ready); end
    in_y0 = gen_val(); in_y1 = gen_val(); in_y2 = gen_val();
    for (int i = 0; i < 3; i++) begin
      step(p);
      vectors++;
      if (p || in_ready !== 1'b0 || out_data !== head) begin
        miscompares++;
        $display("FAIL b2b_hold got pushed=%b in_ready=%b d=%h exp 0 0 %h", p, in_ready, out_data, head);
      end
    end
    out_ready = 1'b1;
    waited = 0;
    p = 1'b0;
    while (!p && waited < 20) begin step(p); waited++; end
    in_valid = 1'b0;
    vectors++;
    if (!p) begin miscompares++; $display("FAIL b2b_accept_timeout got 0 exp 1"); end
    for (int c = 0; c < 30 && out_valid; c++) step(p);
    vectors++;
    if (got_q.size() !== 9 || exp_q.size() !== 9) begin
      miscompares++; $display("FAIL b2b_len got %0d exp %0d (9)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL b2b_sample%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    bit p;
    logic [63:0] blk [10][3];
    int sent;
    logic pv, pr, pl;
    logic [31:0] pd;
    exp_q.delete(); got_q.delete();
    for (int b = 0; b < 10; b++)
      for (int e = 0; e < 3; e++) blk[b][e] = gen_val();
    sent = 0;
    for (int c = 0; c < 400 && (sent < 10 || out_valid); c++) begin
      in_valid = (sent < 10);
      if (sent < 10) begin
        in_y0 = blk[sent][0]; in_y1 = blk[sent][1]; in_y2 = blk[sent][2];
      end
      out_ready = ($urandom % 3) != 0;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      step(p);
      if (p) sent++;
      if (pv && !pr) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          miscompares++;
          $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (sent !== 10 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_timeout got sent=%0d v=%b exp 10 0", sent, out_valid);
    end
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL stall_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL stall_sample%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit p;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_y0 = 64'd11; in_y1 = 64'd22; in_y2 = 64'sh7_0000_0000;
    step(p);
    in_y0 = 64'd33; in_y1 = 64'd44; in_y2 = 64'd55;
    step(p);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(p);
    out_ready = 1'b0;
    vectors++;
    if (out_data !== 32'd22 || sat_flag !== 1'b1) begin
      miscompares++; $display("FAIL midop_setup got d=%0d flag=%b exp 22 1", out_data, sat_flag);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_flag !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset got v=%b rdy=%b flag=%b l=%b exp 0 1 0 0", out_valid, in_ready, sat_flag, out_last);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    flag_m = 1'b0; cnt_m = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_y0 = 64'd7; in_y1 = 64'd8; in_y2 = 64'd9;
    step(p);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd7 || out_last !== 1'b0) begin
      miscompares++; $display("FAIL midop_restart got v=%b d=%0d l=%b exp 1 7 0", out_valid, out_data, out_last);
    end
    for (int c = 0; c < 10 && out_valid; c++) step(p);
    vectors++;
    if (got_q.size() !== 3 || got_q[0] !== exp_q[0] || got_q[2] !== exp_q[2]) begin
      miscompares++; $display("FAIL midop_stream got n=%0d exp 3 samples 7,8,9", got_q.size());
    end
  endtask

  task automatic test_sat_clr_race();
    bit p;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_y0 = -64'sh5_0000_0000; in_y1 = 64'd1; in_y2 = 64'd2;
    sat_clr = 1'b1;
    step(p);
    sat_clr = 1'b0; in_valid = 1'b0;
    vectors++;
    if (sat_flag !== 1'b1 || sat_flag !== flag_m) begin
      miscompares++; $display("FAIL race_sat_flag got %b exp 1", sat_flag);
    end
`ifdef BLOCK_SER_SAT_CNT_EN
    vectors++;
    if (sat_cnt !== 16'(cnt_m)) begin
      miscompares++; $display("FAIL race_sat_cnt got %0d exp %0d", sat_cnt, cnt_m);
    end
`endif
    for (int c = 0; c < 10 && out_valid; c++) step(p);
    vectors++;
    if (got_q.size() !== 3 || got_q[0] !== {1'b0, 32'h8000_0000}) begin
      miscompares++; $display("FAIL race_stream got n=%0d first=%h exp 3 080000000", got_q.size(),
                              (got_q.size() > 0) ? got_q[0] : 33'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_random_stall();
    test_reset_midop();
    test_sat_clr_race();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
